// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store stage between the core data path and a
// variable-latency data memory. It runs a req/ack handshake and stalls the
// core until the access finishes. An aligned access takes IDLE -> REQ -> RESP;
// a misaligned access takes IDLE -> RESP and pulses err.
// Optional feature: define MEM_TIMEOUT_EN to abort a REQ that gets no mem_ack
// within TIMEOUT cycles. An aborted load returns read_data = 0 and pulses err.
module data_mem_ctrl #(
  parameter int WIDTH   = 22,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] read_data,
  output logic             stall,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("data_mem_ctrl: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state_reg, state_next;
  logic             req_reg, req_next;
  logic             we_reg, we_next;
  logic [WIDTH-1:0] addr_reg, addr_next;
  logic [WIDTH-1:0] wdata_reg, wdata_next;
  logic [WIDTH-1:0] rdata_reg, rdata_next;
  logic             err_reg, err_next;

`ifdef MEM_TIMEOUT_EN
  // The counter is at least 8 bits wide, and wider when TIMEOUT needs it.
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

  // Next-state logic, next values of the registered outputs, and the combinational stall
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    err_next   = 1'b0;
    stall      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (mem_read | mem_write) begin
          stall = 1'b1;
          if (addr[1:0] == 2'b00) begin
            // Capture the request. A store wins when both strobes are high.
            state_next = REQ;
            req_next   = 1'b1;
            we_next    = mem_write;
            addr_next  = {addr[WIDTH-1:2], 2'b00};
            wdata_next = wdata;
`ifdef MEM_TIMEOUT_EN
            cnt_next   = '0;
`endif
          end else begin
            state_next = RESP;
            err_next   = 1'b1;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack) begin
          req_next   = 1'b0;
          state_next = RESP;
          if (!we_reg) rdata_next = mem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_reg == CNT_LAST) begin
          req_next   = 1'b0;
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      RESP: begin
        // The core commits at this edge. A request still held here is not restarted.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously when rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
`ifdef MEM_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  assign mem_req   = req_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign read_data = rdata_reg;
  assign err       = err_reg;

endmodule
